// File: rtl/eth_frame_tx.sv
// Ethernet frame generator: buffers one payload from a valid/ready byte stream, then
// emits preamble, SFD, MACs, length, payload and a 4-byte LRC FCS one byte per cycle.
module eth_frame_tx #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter logic [47:0] SRC_MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter int          MAX_PAYLOAD   = 64,
    parameter int          IFG_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       bad_fcs,
    input  logic       sink_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       tx_done,
    output logic       trunc
);

    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int CW = AW + 1;

    function automatic logic [7:0] mac_sum(input logic [47:0] mac);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 6; i++) s = s + mac[8*i +: 8];
        return s;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

    localparam logic [7:0] HDR_SUM = mac_sum(DEST_MAC_ADDR) + mac_sum(SRC_MAC_ADDR);

    typedef enum logic [3:0] {
        S_LOAD, S_WAIT, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PL, S_FCS, S_GAP
    } state_t;

    state_t        state, nxt_state;
    logic [15:0]   cnt, nxt_cnt;
    logic [CW-1:0] count;
    logic [CW-1:0] n;
    logic [15:0]   n16;
    logic [7:0]    sum;
    logic          bad_lat;
    logic [7:0]    mem [MAX_PAYLOAD];
    logic          xfer, full_xfer, close_xfer;
    logic [7:0]    fcs_byte, nxt_byte, s_total;

    assign in_ready   = (state == S_LOAD) && (count < CW'(MAX_PAYLOAD));
    assign xfer       = in_valid && in_ready;
    assign full_xfer  = xfer && (count == CW'(MAX_PAYLOAD - 1));
    assign close_xfer = xfer && (in_last || full_xfer);
    assign n16        = 16'(n);

    // LRC: two's complement of the byte sum over header-after-SFD and payload.
    assign s_total  = HDR_SUM + n16[15:8] + n16[7:0] + sum;
    assign fcs_byte = bad_lat ? ~(~s_total + 8'd1) : (~s_total + 8'd1);

    always_comb begin
        nxt_state = state;
        case (state)
            S_LOAD: if (close_xfer) nxt_state = S_WAIT;
            S_WAIT: if (sink_ready) nxt_state = S_PRE;
            S_PRE:  if (cnt == 16'd6) nxt_state = S_SFD;
            S_SFD:  nxt_state = S_DST;
            S_DST:  if (cnt == 16'd5) nxt_state = S_SRC;
            S_SRC:  if (cnt == 16'd5) nxt_state = S_LEN;
            S_LEN:  if (cnt == 16'd1) nxt_state = S_PL;
            S_PL:   if (cnt == n16 - 16'd1) nxt_state = S_FCS;
            S_FCS:  if (cnt == 16'd3) nxt_state = S_GAP;
            S_GAP:  if (cnt == 16'(IFG_CYCLES - 1)) nxt_state = S_LOAD;
            default: nxt_state = S_LOAD;
        endcase
        nxt_cnt = (nxt_state != state) ? 16'd0 : cnt + 16'd1;
    end

    // Output bytes are registered from the next state, so tx_data lines up with state.
    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_state)
            S_PRE:   nxt_byte = 8'hAA;
            S_SFD:   nxt_byte = 8'hAB;
            S_DST:   nxt_byte = mac_byte(DEST_MAC_ADDR, nxt_cnt[2:0]);
            S_SRC:   nxt_byte = mac_byte(SRC_MAC_ADDR, nxt_cnt[2:0]);
            S_LEN:   nxt_byte = (nxt_cnt == 16'd0) ? n16[15:8] : n16[7:0];
            S_PL:    nxt_byte = mem[nxt_cnt[AW-1:0]];
            S_FCS:   nxt_byte = fcs_byte;
            default: nxt_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            cnt      <= 16'd0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            trunc    <= 1'b0;
            count    <= '0;
            n        <= '0;
            sum      <= 8'h00;
            bad_lat  <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            tx_data  <= nxt_byte;
            tx_start <= (state == S_WAIT) && (nxt_state == S_PRE);
            busy     <= (nxt_state != S_LOAD);
            tx_done  <= (state == S_FCS) && (nxt_state == S_GAP);
            trunc    <= full_xfer && !in_last;
            if (xfer) begin
                count <= count + CW'(1);
                sum   <= sum + in_data;
            end
            if (close_xfer) n <= count + CW'(1);
            if (state == S_WAIT && sink_ready) bad_lat <= bad_fcs;
            if (state == S_GAP && nxt_state == S_LOAD) begin
                count <= '0;
                sum   <= 8'h00;
            end
        end
    end

    // NOTE: the payload buffer has no reset; every byte read is written first in LOAD,
    // and a resettable array would cost a clear path on every entry.
    always_ff @(posedge clk) begin
        if (xfer) mem[count[AW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed testbench for eth_frame_tx: each task drives one scenario and checks
// the emitted byte stream against a frame built from the payload in the bench.
module tb_eth_frame_tx;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       bad_fcs = 1'b0;
    logic       sink_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start, busy, tx_done, trunc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    eth_frame_tx #(
        .DEST_MAC_ADDR(48'h00_0a_95_9d_68_16),
        .SRC_MAC_ADDR (48'h02_00_00_00_00_01),
        .MAX_PAYLOAD  (64),
        .IFG_CYCLES   (4)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .bad_fcs(bad_fcs), .sink_ready(sink_ready), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy), .tx_done(tx_done), .trunc(trunc)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic bq_t build_frame(bq_t pl, bit bad);
        bq_t fr;
        logic [47:0] d = 48'h00_0a_95_9d_68_16;
        logic [47:0] s = 48'h02_00_00_00_00_01;
        logic [15:0] len;
        logic [7:0] sum, f;
        len = 16'(pl.size());
        for (int k = 0; k < 7; k++) fr.push_back(8'hAA);
        fr.push_back(8'hAB);
        for (int k = 0; k < 6; k++) fr.push_back(d[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) fr.push_back(s[47-8*k -: 8]);
        fr.push_back(len[15:8]);
        fr.push_back(len[7:0]);
        foreach (pl[i]) fr.push_back(pl[i]);
        sum = 8'h00;
        for (int k = 8; k < fr.size(); k++) sum = sum + fr[k];
        f = ~sum + 8'd1;
        if (bad) f = ~f;
        for (int k = 0; k < 4; k++) fr.push_back(f);
        return fr;
    endfunction

    task automatic load_payload(input string name, input bq_t pl, input bit use_last,
                                output bit trunc_seen, output bit ready_after);
        int waitc;
        trunc_seen = 1'b0;
        foreach (pl[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pl[i];
            in_last  = use_last && (i == pl.size() - 1);
            waitc = 0;
            while (in_ready !== 1'b1 && waitc < 200) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 200) begin
                checks++;
                errors++;
                $display("FAIL %s load: in_ready stuck at %b for byte %0d, required 1", name, in_ready, i);
            end
        end
        @(negedge clk);
        trunc_seen  = trunc;
        ready_after = in_ready;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_frame(input string name, input bq_t exp, input int max_wait,
                                output int start_cyc);
        int waited = 0;
        int extra = 0;
        int not_busy = 0;
        start_cyc = -1;
        @(negedge clk);
        while (tx_start !== 1'b1 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL %s start: tx_start=%b after %0d cycles, required 1", name, tx_start, waited);
            return;
        end
        start_cyc = cyc;
        foreach (exp[i]) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (tx_data !== exp[i]) begin
                errors++;
                $display("FAIL %s byte %0d: tx_data=%h, required %h", name, i, tx_data, exp[i]);
            end
            if (i > 0 && tx_start !== 1'b0) extra++;
            if (busy !== 1'b1) not_busy++;
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL %s done: tx_done=%b tx_data=%h, required 1 and 00", name, tx_done, tx_data);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL %s start_once: %0d extra tx_start cycles, required 0", name, extra);
        end
        checks++;
        if (not_busy != 0) begin
            errors++;
            $display("FAIL %s busy: %0d frame cycles with busy=0, required 0", name, not_busy);
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: tx_done=%b in second gap cycle, required 0", name, tx_done);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({tx_data, tx_start, busy, tx_done, trunc} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: data=%h start=%b busy=%b done=%b trunc=%b, required all 0",
                     tx_data, tx_start, busy, tx_done, trunc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_single_byte();
        bq_t pl = {8'h55};
        bit tr, rdy;
        int sc;
        sink_ready = 1'b1;
        load_payload("single", pl, 1'b1, tr, rdy);
        checks++;
        if (tr !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL single load_end: trunc=%b in_ready=%b, required 0 0", tr, rdy);
        end
        expect_frame("single", build_frame(pl, 1'b0), 10, sc);
    endtask

    task automatic test_sink_wait();
        bq_t pl = {8'hA1, 8'hB2, 8'hC3};
        bit tr, rdy;
        int sc;
        int bad_cycles = 0;
        sink_ready = 1'b0;
        load_payload("sink_wait", pl, 1'b1, tr, rdy);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h00 || in_ready !== 1'b0)
                bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0 || tr !== 1'b0) begin
            errors++;
            $display("FAIL sink_wait hold: %0d bad cycles (busy=%b start=%b data=%h ready=%b) trunc=%b, required 0 bad, trunc 0",
                     bad_cycles, busy, tx_start, tx_data, in_ready, tr);
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        sink_ready = 1'b1;
        expect_frame("sink_wait", build_frame(pl, 1'b0), 0, sc);
    endtask

    task automatic test_truncation();
        bq_t pl;
        bit tr, rdy;
        int sc;
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        load_payload("trunc", pl, 1'b0, tr, rdy);
        checks++;
        if (tr !== 1'b1 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL trunc flags: trunc=%b in_ready=%b, required 1 0", tr, rdy);
        end
        expect_frame("trunc", build_frame(pl, 1'b0), 10, sc);
    endtask

    task automatic test_bad_fcs();
        bq_t pl = {8'h55};
        bit tr, rdy;
        int sc;
        bad_fcs = 1'b1;
        load_payload("bad_fcs", pl, 1'b1, tr, rdy);
        expect_frame("bad_fcs", build_frame(pl, 1'b1), 10, sc);
        bad_fcs = 1'b0;
    endtask

    task automatic test_async_reset();
        bq_t pl = {8'h11, 8'h22, 8'h33};
        bq_t pl2 = {8'h5A, 8'hC3};
        bit tr, rdy;
        int waited = 0;
        int sc;
        load_payload("async_rst", pl, 1'b1, tr, rdy);
        while (tx_start !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (23) @(negedge clk);
        checks++;
        if (tx_data !== 8'h22 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_rst pre: tx_data=%h busy=%b, required 22 1", tx_data, busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({tx_data, tx_start, busy, tx_done, trunc} !== 12'h000) begin
            errors++;
            $display("FAIL async_rst outputs: data=%h start=%b busy=%b done=%b trunc=%b, required all 0",
                     tx_data, tx_start, busy, tx_done, trunc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        load_payload("after_rst", pl2, 1'b1, tr, rdy);
        expect_frame("after_rst", build_frame(pl2, 1'b0), 10, sc);
    endtask

    task automatic test_back_to_back();
        bq_t p1 = {8'h01, 8'h80};
        bq_t p2 = {8'hFF, 8'h00, 8'h7E};
        bit tr, rdy;
        int s1, s2;
        load_payload("b2b_1", p1, 1'b1, tr, rdy);
        expect_frame("b2b_1", build_frame(p1, 1'b0), 10, s1);
        load_payload("b2b_2", p2, 1'b1, tr, rdy);
        expect_frame("b2b_2", build_frame(p2, 1'b0), 10, s2);
        checks++;
        if (s1 < 0 || s2 < 0 || (s2 - s1) < 26 + 2 + 4 + 3 + 1) begin
            errors++;
            $display("FAIL b2b spacing: start gap=%0d cycles, required >= %0d", s2 - s1, 26 + 2 + 4 + 3 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_sink_wait();
        test_truncation();
        test_bad_fcs();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
